// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the 16x73 memory arbiter/sequencer.
package mem_arb_pkg;

  localparam int MEM_DEPTH  = 16;
  localparam int MEM_DATA_W = 73;

  typedef enum logic {
    REQ_A = 1'b0,
    REQ_B = 1'b1
  } req_id_e;

  typedef enum logic {
    ST_INIT = 1'b0,
    ST_RUN  = 1'b1
  } arb_state_e;

  typedef struct packed {
    logic    valid;
    req_id_e id;
  } tag_t;

endpackage

// File: rtl/mem_arb_rr2.sv
// Two-way round-robin grant; the priority pointer moves only on an accepted grant.
module mem_arb_rr2
  import mem_arb_pkg::*;
(
  input  logic clk,
  input  logic rst_n,
  input  logic en,
  input  logic a_valid,
  input  logic b_valid,
  output logic a_gnt,
  output logic b_gnt
);

  req_id_e prio_r;

  // grant selection: single requester wins outright, conflicts go to prio_r
  always_comb begin
    a_gnt = 1'b0;
    b_gnt = 1'b0;
    if (en) begin
      if (a_valid && b_valid) begin
        if (prio_r == REQ_A) begin
          a_gnt = 1'b1;
        end else begin
          b_gnt = 1'b1;
        end
      end else begin
        a_gnt = a_valid;
        b_gnt = b_valid;
      end
    end else begin
      a_gnt = 1'b0;
      b_gnt = 1'b0;
    end
  end

  // pointer hands priority to the requester not granted last
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      prio_r <= REQ_A;
    end else if (a_gnt) begin
      prio_r <= REQ_B;
    end else if (b_gnt) begin
      prio_r <= REQ_A;
    end else begin
      prio_r <= prio_r;
    end
  end

endmodule

// File: rtl/mem_16x73_arb.sv
// Two-requester arbiter/sequencer for the 16x73 memory macro (2-clock read latency).
// Optional power-up zero fill of the macro is enabled by defining MEM_16X73_ARB_INIT_EN.
module mem_16x73_arb
  import mem_arb_pkg::*;
#(
  parameter int ADDR_W = 4,
  parameter int DATA_W = MEM_DATA_W,
  parameter int RD_LAT = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              a_req_valid,
  output logic              a_req_ready,
  input  logic              a_req_wr,
  input  logic [ADDR_W-1:0] a_req_addr,
  input  logic [DATA_W-1:0] a_req_wdata,
  output logic              a_rsp_valid,
  output logic [DATA_W-1:0] a_rsp_data,
  input  logic              b_req_valid,
  output logic              b_req_ready,
  input  logic              b_req_wr,
  input  logic [ADDR_W-1:0] b_req_addr,
  input  logic [DATA_W-1:0] b_req_wdata,
  output logic              b_rsp_valid,
  output logic [DATA_W-1:0] b_rsp_data,
  output logic              mem_wr_en,
  output logic [ADDR_W-1:0] mem_wr_addr,
  output logic [DATA_W-1:0] mem_wr_data,
  output logic              mem_rd_en,
  output logic [ADDR_W-1:0] mem_rd_addr,
  input  logic [DATA_W-1:0] mem_rd_data,
  output logic              busy
);

  arb_state_e        state_r;
  arb_state_e        state_nxt_s;
  logic              init_s;
  logic              en_s;
  logic              gnt_a_s;
  logic              gnt_b_s;
  logic              acc_s;
  logic              sel_wr_s;
  logic [ADDR_W-1:0] sel_addr_s;
  logic [DATA_W-1:0] sel_wdata_s;
  req_id_e           sel_id_s;
  tag_t              tag_r [RD_LAT+1];
  logic              rd_pend_s;
  logic              hit_a_s;
  logic              hit_b_s;

`ifdef MEM_16X73_ARB_INIT_EN
  logic [ADDR_W-1:0] init_cnt_r;

  // zero-fill address counter, advances only while in INIT
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      init_cnt_r <= {ADDR_W{1'b0}};
    end else if (init_s) begin
      init_cnt_r <= init_cnt_r + {{(ADDR_W-1){1'b0}}, 1'b1};
    end else begin
      init_cnt_r <= init_cnt_r;
    end
  end

  assign init_s = (state_r == ST_INIT);
`else
  assign init_s = 1'b0;
`endif

  // state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
`ifdef MEM_16X73_ARB_INIT_EN
      state_r <= ST_INIT;
`else
      state_r <= ST_RUN;
`endif
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // next state: INIT leaves after the last fill address
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      ST_INIT: begin
`ifdef MEM_16X73_ARB_INIT_EN
        if (init_cnt_r == {ADDR_W{1'b1}}) begin
          state_nxt_s = ST_RUN;
        end else begin
          state_nxt_s = ST_INIT;
        end
`else
        state_nxt_s = ST_RUN;
`endif
      end
      ST_RUN:  state_nxt_s = ST_RUN;
      default: state_nxt_s = ST_RUN;
    endcase
  end

  // rst_n in the enable keeps ready low while reset is held
  assign en_s = (state_r == ST_RUN) & rst_n;

  mem_arb_rr2 u_rr2 (
    .clk     (clk),
    .rst_n   (rst_n),
    .en      (en_s),
    .a_valid (a_req_valid),
    .b_valid (b_req_valid),
    .a_gnt   (gnt_a_s),
    .b_gnt   (gnt_b_s)
  );

  assign a_req_ready = gnt_a_s;
  assign b_req_ready = gnt_b_s;
  assign acc_s       = gnt_a_s | gnt_b_s;

  // payload of the granted requester
  always_comb begin
    sel_wr_s    = 1'b0;
    sel_addr_s  = {ADDR_W{1'b0}};
    sel_wdata_s = {DATA_W{1'b0}};
    sel_id_s    = REQ_A;
    if (gnt_b_s) begin
      sel_wr_s    = b_req_wr;
      sel_addr_s  = b_req_addr;
      sel_wdata_s = b_req_wdata;
      sel_id_s    = REQ_B;
    end else begin
      sel_wr_s    = a_req_wr;
      sel_addr_s  = a_req_addr;
      sel_wdata_s = a_req_wdata;
      sel_id_s    = REQ_A;
    end
  end

  // macro port registers; addresses and data hold on idle cycles
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem_wr_en   <= 1'b0;
      mem_wr_addr <= {ADDR_W{1'b0}};
      mem_wr_data <= {DATA_W{1'b0}};
      mem_rd_en   <= 1'b0;
      mem_rd_addr <= {ADDR_W{1'b0}};
    end
`ifdef MEM_16X73_ARB_INIT_EN
    else if (init_s) begin
      mem_wr_en   <= 1'b1;
      mem_wr_addr <= init_cnt_r;
      mem_wr_data <= {DATA_W{1'b0}};
      mem_rd_en   <= 1'b0;
      mem_rd_addr <= mem_rd_addr;
    end
`endif
    else begin
      mem_wr_en <= acc_s & sel_wr_s;
      mem_rd_en <= acc_s & ~sel_wr_s;
      if (acc_s && sel_wr_s) begin
        mem_wr_addr <= sel_addr_s;
        mem_wr_data <= sel_wdata_s;
      end else begin
        mem_wr_addr <= mem_wr_addr;
        mem_wr_data <= mem_wr_data;
      end
      if (acc_s && !sel_wr_s) begin
        mem_rd_addr <= sel_addr_s;
      end else begin
        mem_rd_addr <= mem_rd_addr;
      end
    end
  end

  // read tag pipeline: stage 0 lines up with mem_rd_en, last stage with mem_rd_data
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i <= RD_LAT; i++) begin
        tag_r[i] <= '{valid: 1'b0, id: REQ_A};
      end
    end else begin
      tag_r[0] <= '{valid: (acc_s & ~sel_wr_s), id: sel_id_s};
      for (int i = 1; i <= RD_LAT; i++) begin
        tag_r[i] <= tag_r[i-1];
      end
    end
  end

  // any read still travelling through the macro
  always_comb begin
    rd_pend_s = 1'b0;
    for (int i = 0; i <= RD_LAT; i++) begin
      rd_pend_s = rd_pend_s | tag_r[i].valid;
    end
  end

  assign busy    = rst_n & (init_s | rd_pend_s);
  assign hit_a_s = tag_r[RD_LAT].valid & (tag_r[RD_LAT].id == REQ_A);
  assign hit_b_s = tag_r[RD_LAT].valid & (tag_r[RD_LAT].id == REQ_B);

  // response capture and steering; the other requester's data holds
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_rsp_valid <= 1'b0;
      a_rsp_data  <= {DATA_W{1'b0}};
      b_rsp_valid <= 1'b0;
      b_rsp_data  <= {DATA_W{1'b0}};
    end else begin
      a_rsp_valid <= hit_a_s;
      b_rsp_valid <= hit_b_s;
      if (hit_a_s) begin
        a_rsp_data <= mem_rd_data;
      end else begin
        a_rsp_data <= a_rsp_data;
      end
      if (hit_b_s) begin
        b_rsp_data <= mem_rd_data;
      end else begin
        b_rsp_data <= b_rsp_data;
      end
    end
  end

endmodule

// File: tb/tb_mem_16x73_arb.sv
// Directed bench for mem_16x73_arb with a behavioural 16x73 macro (2-clock read latency).
module tb_mem_16x73_arb;
  localparam int AW = 4;
  localparam int DW = 73;

  localparam logic [DW-1:0] D1  = 73'h1_2345_6789_ABCD_EF01;
  localparam logic [DW-1:0] D8  = 73'h0_8888_0000_1111_2222;
  localparam logic [DW-1:0] D9  = 73'h1_9999_3333_4444_5555;
  localparam logic [DW-1:0] D10 = 73'h0_AAAA_6666_7777_8888;
  localparam logic [DW-1:0] D11 = 73'h1_BBBB_9999_0000_CCCC;
  localparam logic [DW-1:0] DY  = 73'h0_5555_5555_5555_5555;
  localparam logic [DW-1:0] DX  = 73'h1_0F0F_F0F0_1234_4321;
  localparam logic [DW-1:0] D15 = 73'h1_FFFF_0000_FFFF_0015;
  localparam logic [DW-1:0] D0  = 73'h0_0000_FFFF_0000_FF00;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          a_req_valid, a_req_ready, a_req_wr;
  logic [AW-1:0] a_req_addr;
  logic [DW-1:0] a_req_wdata;
  logic          a_rsp_valid;
  logic [DW-1:0] a_rsp_data;
  logic          b_req_valid, b_req_ready, b_req_wr;
  logic [AW-1:0] b_req_addr;
  logic [DW-1:0] b_req_wdata;
  logic          b_rsp_valid;
  logic [DW-1:0] b_rsp_data;
  logic          mem_wr_en, mem_rd_en, busy;
  logic [AW-1:0] mem_wr_addr, mem_rd_addr;
  logic [DW-1:0] mem_wr_data, mem_rd_data;

  logic [DW-1:0] mem_model [16];
  logic [DW-1:0] rd_p1, rd_p2;
  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  mem_16x73_arb dut (
    .clk(clk), .rst_n(rst_n),
    .a_req_valid(a_req_valid), .a_req_ready(a_req_ready), .a_req_wr(a_req_wr),
    .a_req_addr(a_req_addr), .a_req_wdata(a_req_wdata),
    .a_rsp_valid(a_rsp_valid), .a_rsp_data(a_rsp_data),
    .b_req_valid(b_req_valid), .b_req_ready(b_req_ready), .b_req_wr(b_req_wr),
    .b_req_addr(b_req_addr), .b_req_wdata(b_req_wdata),
    .b_rsp_valid(b_rsp_valid), .b_rsp_data(b_rsp_data),
    .mem_wr_en(mem_wr_en), .mem_wr_addr(mem_wr_addr), .mem_wr_data(mem_wr_data),
    .mem_rd_en(mem_rd_en), .mem_rd_addr(mem_rd_addr), .mem_rd_data(mem_rd_data),
    .busy(busy)
  );

  // macro model: write and read sampled at the edge, read data two edges later
  always @(posedge clk) begin
    if (mem_wr_en) mem_model[mem_wr_addr] <= mem_wr_data;
    if (mem_rd_en) rd_p1 <= mem_model[mem_rd_addr];
    rd_p2 <= rd_p1;
  end
  assign mem_rd_data = rd_p2;

  task automatic chk1(input string tag, input logic obs, input logic exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  task automatic chka(input string tag, input logic [AW-1:0] obs, input logic [AW-1:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic chkd(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task set_a(input logic v, input logic w, input logic [AW-1:0] ad, input logic [DW-1:0] d);
    a_req_valid = v; a_req_wr = w; a_req_addr = ad; a_req_wdata = d;
  endtask

  task set_b(input logic v, input logic w, input logic [AW-1:0] ad, input logic [DW-1:0] d);
    b_req_valid = v; b_req_wr = w; b_req_addr = ad; b_req_wdata = d;
  endtask

  task chk_zero(input string t);
    chk1({t, "_a_rdy"}, a_req_ready, 1'b0);
    chk1({t, "_b_rdy"}, b_req_ready, 1'b0);
    chk1({t, "_a_rv"}, a_rsp_valid, 1'b0);
    chkd({t, "_a_rd"}, a_rsp_data, {DW{1'b0}});
    chk1({t, "_b_rv"}, b_rsp_valid, 1'b0);
    chkd({t, "_b_rd"}, b_rsp_data, {DW{1'b0}});
    chk1({t, "_wen"}, mem_wr_en, 1'b0);
    chka({t, "_wad"}, mem_wr_addr, 4'd0);
    chkd({t, "_wd"}, mem_wr_data, {DW{1'b0}});
    chk1({t, "_ren"}, mem_rd_en, 1'b0);
    chka({t, "_rad"}, mem_rd_addr, 4'd0);
    chk1({t, "_busy"}, busy, 1'b0);
  endtask

  initial begin
    rst_n = 1'b0;
    set_a(1'b1, 1'b0, 4'd0, {DW{1'b0}});
    set_b(1'b1, 1'b0, 4'd0, {DW{1'b0}});
    step(); step(); #1;
    chk_zero("rst0");

    rst_n = 1'b1;
    set_a(1'b0, 1'b0, 4'd0, {DW{1'b0}});
    set_b(1'b0, 1'b0, 4'd0, {DW{1'b0}});
`ifdef MEM_16X73_ARB_INIT_EN
    // zero fill: ready held low for 16 cycles, then the first request is taken
    set_a(1'b1, 1'b0, 4'd7, {DW{1'b0}});
    #1;
    chk1("init_rdy0", a_req_ready, 1'b0);
    chk1("init_busy0", busy, 1'b1);
    for (int k = 1; k <= 16; k++) begin
      step(); #1;
      chk1("init_wen", mem_wr_en, 1'b1);
      chka("init_wad", mem_wr_addr, AW'(k - 1));
      chkd("init_wd", mem_wr_data, {DW{1'b0}});
      if (k < 16) begin
        chk1("init_rdy", a_req_ready, 1'b0);
        chk1("init_busy", busy, 1'b1);
      end else begin
        chk1("init_rdy17", a_req_ready, 1'b1);
      end
    end
    step();
    set_a(1'b0, 1'b0, 4'd0, {DW{1'b0}});
    step(); step(); step();
    chk1("init_rsp_v", a_rsp_valid, 1'b1);
    chkd("init_rsp_d", a_rsp_data, {DW{1'b0}});
    step();
`endif

    // T1: A writes addr 3 then reads it back
    set_a(1'b1, 1'b1, 4'd3, D1); #1;
    chk1("t1_a_rdy", a_req_ready, 1'b1);
    chk1("t1_b_rdy", b_req_ready, 1'b0);
    step();
    chk1("t1_wen", mem_wr_en, 1'b1);
    chka("t1_wad", mem_wr_addr, 4'd3);
    chkd("t1_wd", mem_wr_data, D1);
    chk1("t1_ren0", mem_rd_en, 1'b0);
    set_a(1'b1, 1'b0, 4'd3, {DW{1'b0}}); #1;
    chk1("t1_rd_rdy", a_req_ready, 1'b1);
    step();
    set_a(1'b0, 1'b0, 4'd0, {DW{1'b0}});
    chk1("t1_ren", mem_rd_en, 1'b1);
    chka("t1_rad", mem_rd_addr, 4'd3);
    chk1("t1_wen0", mem_wr_en, 1'b0);
    chk1("t1_busy", busy, 1'b1);
    step(); chk1("t1_early2", a_rsp_valid, 1'b0);
    step(); chk1("t1_early3", a_rsp_valid, 1'b0);
    step();
    chk1("t1_rsp_v", a_rsp_valid, 1'b1);
    chkd("t1_rsp_d", a_rsp_data, D1);
    chk1("t1_b_rv", b_rsp_valid, 1'b0);
    chk1("t1_busy0", busy, 1'b0);
    step();
    chk1("t1_pulse", a_rsp_valid, 1'b0);

    // T2 preload: A writes 8,9,10 back to back, B writes 11 (last grant B)
    set_a(1'b1, 1'b1, 4'd8, D8); step();
    set_a(1'b1, 1'b1, 4'd9, D9); step();
    set_a(1'b1, 1'b1, 4'd10, D10); step();
    set_a(1'b0, 1'b0, 4'd0, {DW{1'b0}});
    set_b(1'b1, 1'b1, 4'd11, D11); #1;
    chk1("t2_bw_rdy", b_req_ready, 1'b1);
    step();
    chk1("t2_bw_wen", mem_wr_en, 1'b1);
    chka("t2_bw_wad", mem_wr_addr, 4'd11);
    // T2: both requesters reading continuously
    set_a(1'b1, 1'b0, 4'd8, {DW{1'b0}});
    set_b(1'b1, 1'b0, 4'd10, {DW{1'b0}}); #1;
    chk1("t2_s0_a", a_req_ready, 1'b1);
    chk1("t2_s0_b", b_req_ready, 1'b0);
    step();
    set_a(1'b1, 1'b0, 4'd9, {DW{1'b0}}); #1;
    chk1("t2_s1_b", b_req_ready, 1'b1);
    chk1("t2_s1_a", a_req_ready, 1'b0);
    chk1("t2_s1_ren", mem_rd_en, 1'b1);
    chka("t2_s1_rad", mem_rd_addr, 4'd8);
    step();
    set_b(1'b1, 1'b0, 4'd11, {DW{1'b0}}); #1;
    chk1("t2_s2_a", a_req_ready, 1'b1);
    chk1("t2_s2_ren", mem_rd_en, 1'b1);
    chka("t2_s2_rad", mem_rd_addr, 4'd10);
    step();
    set_a(1'b1, 1'b0, 4'd8, {DW{1'b0}}); #1;
    chk1("t2_s3_b", b_req_ready, 1'b1);
    chk1("t2_s3_a", a_req_ready, 1'b0);
    chka("t2_s3_rad", mem_rd_addr, 4'd9);
    step();
    set_a(1'b0, 1'b0, 4'd0, {DW{1'b0}});
    set_b(1'b0, 1'b0, 4'd0, {DW{1'b0}});
    chk1("t2_s4_ren", mem_rd_en, 1'b1);
    chka("t2_s4_rad", mem_rd_addr, 4'd11);
    chk1("t2_s4_av", a_rsp_valid, 1'b1);
    chkd("t2_s4_ad", a_rsp_data, D8);
    step();
    chk1("t2_s5_ren", mem_rd_en, 1'b0);
    chk1("t2_s5_bv", b_rsp_valid, 1'b1);
    chkd("t2_s5_bd", b_rsp_data, D10);
    chk1("t2_s5_av", a_rsp_valid, 1'b0);
    chkd("t2_s5_hold", a_rsp_data, D8);
    step();
    chk1("t2_s6_av", a_rsp_valid, 1'b1);
    chkd("t2_s6_ad", a_rsp_data, D9);
    step();
    chk1("t2_s7_bv", b_rsp_valid, 1'b1);
    chkd("t2_s7_bd", b_rsp_data, D11);
    chk1("t2_s7_av", a_rsp_valid, 1'b0);

    // T3: read of addr 5 the cycle after writing it returns the new data
    set_a(1'b1, 1'b1, 4'd5, DY); step();
    set_a(1'b1, 1'b1, 4'd5, DX); step();
    set_a(1'b1, 1'b0, 4'd5, {DW{1'b0}}); #1;
    chk1("t3_rdy", a_req_ready, 1'b1);
    step();
    set_a(1'b0, 1'b0, 4'd0, {DW{1'b0}});
    chk1("t3_ren", mem_rd_en, 1'b1);
    chka("t3_rad", mem_rd_addr, 4'd5);
    step(); step(); step();
    chk1("t3_rv", a_rsp_valid, 1'b1);
    chkd("t3_rd", a_rsp_data, DX);

    // T4: B reads 15 then 0 back to back
    set_b(1'b1, 1'b1, 4'd15, D15); step();
    set_b(1'b1, 1'b1, 4'd0, D0); step();
    set_b(1'b1, 1'b0, 4'd15, {DW{1'b0}}); #1;
    chk1("t4_rdy", b_req_ready, 1'b1);
    step();
    set_b(1'b1, 1'b0, 4'd0, {DW{1'b0}});
    chk1("t4_ren1", mem_rd_en, 1'b1);
    chka("t4_rad1", mem_rd_addr, 4'd15);
    step();
    set_b(1'b0, 1'b0, 4'd0, {DW{1'b0}});
    chk1("t4_ren2", mem_rd_en, 1'b1);
    chka("t4_rad2", mem_rd_addr, 4'd0);
    step();
    chk1("t4_ren3", mem_rd_en, 1'b0);
    step();
    chk1("t4_bv1", b_rsp_valid, 1'b1);
    chkd("t4_bd1", b_rsp_data, D15);
    chk1("t4_av", a_rsp_valid, 1'b0);
    step();
    chk1("t4_bv2", b_rsp_valid, 1'b1);
    chkd("t4_bd2", b_rsp_data, D0);

    // T5: reset one cycle after a read acceptance drops that read
    step();
    set_a(1'b1, 1'b0, 4'd3, {DW{1'b0}}); #1;
    chk1("t5_rdy", a_req_ready, 1'b1);
    step();
    rst_n = 1'b0;
    set_b(1'b1, 1'b0, 4'd0, {DW{1'b0}}); #1;
    chk_zero("t5_rst1");
    step();
    chk_zero("t5_rst2");
    rst_n = 1'b1;
`ifdef MEM_16X73_ARB_INIT_EN
    set_a(1'b0, 1'b0, 4'd0, {DW{1'b0}});
    set_b(1'b0, 1'b0, 4'd0, {DW{1'b0}});
    repeat (16) step();
`endif
    set_a(1'b1, 1'b0, 4'd3, {DW{1'b0}});
    set_b(1'b1, 1'b0, 4'd0, {DW{1'b0}}); #1;
    chk1("t5_post_a", a_req_ready, 1'b1);
    chk1("t5_post_b", b_req_ready, 1'b0);
    step();
    set_a(1'b0, 1'b0, 4'd0, {DW{1'b0}});
    set_b(1'b0, 1'b0, 4'd0, {DW{1'b0}});
    for (int i = 0; i < 3; i++) begin
      chk1("t5_no_av", a_rsp_valid, 1'b0);
      chk1("t5_no_bv", b_rsp_valid, 1'b0);
      step();
    end
    chk1("t5_new_av", a_rsp_valid, 1'b1);
`ifdef MEM_16X73_ARB_INIT_EN
    chkd("t5_new_ad", a_rsp_data, {DW{1'b0}});
`else
    chkd("t5_new_ad", a_rsp_data, D1);
`endif
    step();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/mem_16x73_arb.md
Name: mem_16x73_arb

Overview:
- Two-requester arbiter and sequencer for the 16x73 processor memory macro (2-clock read latency).
- Accepts read/write requests from ports A and B on valid/ready handshakes.
- Grants at most one memory operation per cycle, round-robin.
- Drives the macro's functional write/read ports, tracks in-flight reads and steers returned data to the originating requester.

Parameters:
- ADDR_W, 4: memory address width (depth 2**ADDR_W = 16).
- DATA_W, 73: memory word width.
- RD_LAT, 2: macro cycles from mem_rd_en sampled to mem_rd_data valid.

Ports:
- clk  input  1  single clock for the block and the memory functional port.
- rst_n  input  1  asynchronous, active-low reset.
- a_req_valid  input  1  requester A has a request.
- a_req_ready  output  1  A request accepted this cycle.
- a_req_wr  input  1  1 = write, 0 = read.
- a_req_addr  input  ADDR_W  address.
- a_req_wdata  input  DATA_W  write data.
- a_rsp_valid  output  1  read data for A valid (single-cycle pulse, no backpressure).
- a_rsp_data  output  DATA_W  read data for A.
- b_req_valid, b_req_ready, b_req_wr, b_req_addr, b_req_wdata, b_rsp_valid, b_rsp_data: same as A, for requester B.
- mem_wr_en  output  1  macro write enable.
- mem_wr_addr  output  ADDR_W  macro write address.
- mem_wr_data  output  DATA_W  macro write data.
- mem_rd_en  output  1  macro read enable.
- mem_rd_addr  output  ADDR_W  macro read address.
- mem_rd_data  input  DATA_W  macro read data.
- busy  output  1  init in progress or any read in flight.

Behaviour:
- Reset values: all outputs 0; rr pointer = A (A wins the first conflict).
- States: INIT (only with the optional feature), RUN. Without the feature, reset goes to RUN.
- Grant is combinational in RUN:
  - Only one valid: that requester gets ready=1.
  - Both valid: the requester not granted last gets ready=1.
  - The rr pointer updates only on an accepted grant.
  - a_req_ready and b_req_ready are never both 1.
  - ready is 0 in INIT.
- Requests may change while ready=0. Requesters hold valid plus payload until ready; this is a requester obligation, not checked.
- Acceptance = valid & ready at edge E0. In the following cycle (cycle 1), mem_* outputs are registered:
  - Write: mem_wr_en=1 with addr/data.
  - Read: mem_rd_en=1 with addr.
  - mem_wr_en and mem_rd_en are never both 1.
  - Idle cycles: enables 0; addr/data hold their last values.
- Read tag pipeline of depth RD_LAT+1 carries {valid, requester id}:
  - mem_rd_data is valid in cycle 1+RD_LAT (cycle 3).
  - It is registered into x_rsp_data, with x_rsp_valid pulsed in cycle 4. Read latency is 4 cycles from acceptance.
  - The non-selected rsp_data holds its previous value.
- Throughput: one operation per cycle, back-to-back, mixed read/write, no bubbles.
- Ordering:
  - Operations reach the macro in grant order.
  - A read accepted the cycle after a write to the same address returns the new data, because the macro writes before the later read edge.
  - Responses return in order per requester and globally.
- Reset mid-operation: in-flight tags are cleared; no rsp_valid for reads pending at reset.

Optional Feature:
- Macro MEM_16X73_ARB_INIT_EN.
- Defined:
  - After reset the block enters INIT and writes 0 to addresses 0..15 (mem_wr_en=1 for 16 consecutive cycles).
  - A 4-bit counter wraps 15→RUN; busy=1 and both ready=0 throughout.
  - First request acceptance is possible in the 17th cycle after reset release.
- Undefined: no INIT state, no counter; requests can be accepted in the first cycle after reset release; memory contents are undefined until written.

Decomposition:
- Shared package mem_arb_pkg:
  - Requester-id typedef (REQ_A=0, REQ_B=1).
  - State enum (INIT, RUN).
  - Tag struct {valid, id}.
  - Constants MEM_DEPTH=16, MEM_DATA_W=73.
- One natural sub-module: mem_arb_rr2, the 2-way round-robin grant with last-grant pointer. The tag pipeline stays inline.

Test Plan:
- A writes addr 3 = 73'h1_2345_6789_ABCD_EF01, then reads addr 3 → a_rsp_valid pulses 4 cycles after read acceptance with that data; b_rsp_valid stays 0.
- A and B both valid continuously with reads of different addresses → grants alternate A,B,A,B; responses return alternating with correct data; 1 op/cycle.
- Write addr 5 = X accepted in cycle n, read addr 5 accepted in cycle n+1 → returned data = X.
- Read addr 15 then read addr 0 back to back → address 15 → 0 correct, no wrap corruption; mem_rd_en high 2 consecutive cycles.
- rst_n asserted low 1 cycle after a read acceptance → no rsp_valid ever for that read; all outputs 0 during reset.
- With MEM_16X73_ARB_INIT_EN: release reset with a_req_valid=1 → 16 zero writes to addresses 0..15 and busy=1; a_req_ready first rises in cycle 17; read of any address returns 0.
